// File: rtl/isfft_frame_sched.sv
// 64-point ISFFT frame scheduler: buffers an 8x8 frame, time-shares one 8-point
// engine over 8 column passes (inverse) and 8 row passes (forward), then streams out.
module isfft_frame_sched #(
  parameter int ENG_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [23:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [23:0]  m_data,
  output logic         m_last,
  output logic         busy,
  output logic         eng_vld,
  output logic         eng_mode,
  output logic [2:0]   eng_idx,
  output logic [191:0] eng_din,
  input  logic [191:0] eng_dout
);

  typedef enum logic [2:0] {LOAD, COL, DRN_C, ROW, DRN_R, UNLOAD} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ready_en;
  logic        busy_q;
  logic        wr_en, wr_mode;
  logic [2:0]  wr_idx;
  logic [23:0] mem [64];

  // Column pass touches buf[c+8m]; row pass touches buf[8r+k].
  function automatic logic [5:0] lane_addr(input logic mode, input logic [2:0] idx,
                                           input logic [2:0] lane);
    return mode ? {idx, lane} : {lane, idx};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LOAD;
      cnt_q    <= '0;
      ready_en <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_en <= 1'b1;
      if (s_valid && s_ready)
        busy_q <= 1'b1;
      else if (m_valid && m_ready && m_last)
        busy_q <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    eng_vld  = 1'b0;
    eng_mode = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready = ready_en;
        if (s_valid && ready_en) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = COL;
        end
      end
      COL: begin
        eng_vld = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          state_d = (ENG_LAT == 0) ? ROW : DRN_C;
        end
      end
      DRN_C: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ENG_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ROW;
        end
      end
      ROW: begin
        eng_vld  = 1'b1;
        eng_mode = 1'b1;
        cnt_d    = cnt_q + 6'd1;
        if (cnt_q == 6'd7) begin
          cnt_d   = '0;
          state_d = (ENG_LAT == 0) ? UNLOAD : DRN_R;
        end
      end
      DRN_R: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ENG_LAT - 1)) begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        cnt_d   = '0;
      end
    endcase
  end

  assign eng_idx = eng_vld ? cnt_q[2:0] : 3'd0;
  assign m_data  = m_valid ? mem[cnt_q] : 24'd0;
  assign m_last  = m_valid && (cnt_q == 6'd63);
  assign busy    = busy_q;

  always_comb begin
    eng_din = '0;
    if (eng_vld)
      for (int m = 0; m < 8; m++)
        eng_din[24*m +: 24] = mem[lane_addr(eng_mode, eng_idx, 3'(m))];
  end

  // Tags travel alongside the engine so each result returns to the addresses it came from.
  if (ENG_LAT == 0) begin : g_comb_eng
    assign wr_en   = eng_vld;
    assign wr_mode = eng_mode;
    assign wr_idx  = eng_idx;
  end else begin : g_tag_pipe
    logic [ENG_LAT-1:0]      tag_vld;
    logic [ENG_LAT-1:0]      tag_mode;
    logic [ENG_LAT-1:0][2:0] tag_idx;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tag_vld  <= '0;
        tag_mode <= '0;
        tag_idx  <= '0;
      end else begin
        tag_vld[0]  <= eng_vld;
        tag_mode[0] <= eng_mode;
        tag_idx[0]  <= eng_idx;
        for (int i = 1; i < ENG_LAT; i++) begin
          tag_vld[i]  <= tag_vld[i-1];
          tag_mode[i] <= tag_mode[i-1];
          tag_idx[i]  <= tag_idx[i-1];
        end
      end
    end

    assign wr_en   = tag_vld[ENG_LAT-1];
    assign wr_mode = tag_mode[ENG_LAT-1];
    assign wr_idx  = tag_idx[ENG_LAT-1];
  end

  // NOTE: the frame buffer has no reset; every entry is rewritten by LOAD before it is read.
  always_ff @(posedge clk) begin
    if (s_valid && s_ready)
      mem[cnt_q] <= s_data;
    if (wr_en)
      for (int m = 0; m < 8; m++)
        mem[lane_addr(wr_mode, wr_idx, 3'(m))] <= eng_dout[24*m +: 24];
  end

endmodule

// File: doc/isfft_frame_sched.md
Name: isfft_frame_sched

Overview:
- Frame-level scheduler that computes the 64-point ISFFT on a 12-bit complex 8x8 grid using one shared 8-point transform engine, instead of 16 parallel engine instances.
- Accepts a 64-sample frame over a stream input and stores it in an internal frame buffer.
- Runs 8 column passes through the engine in inverse mode, writing results back into the buffer, then 8 row passes in forward mode.
- Streams the 64 results out in natural order.

Parameters:
- ENG_LAT, 1, engine pipeline latency in clock cycles from eng_vld issue to eng_dout valid; legal range 0..4, where 0 means a combinational engine.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler accepts input sample
- s_data  in  24  input sample {imag[23:12], real[11:0]}, two's complement
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts output sample
- m_data  out  24  output sample {imag, real}
- m_last  out  1  high with the 64th output sample
- busy  out  1  high from the first accepted sample until the last output handshake
- eng_vld  out  1  engine vector issue strobe
- eng_mode  out  1  0 = inverse 8-point (column pass), 1 = forward 8-point (row pass)
- eng_idx  out  3  column or row index of the issued vector
- eng_din  out  192  8 lanes; lane m occupies bits [24m+23:24m]
- eng_dout  in  192  engine result, same lane packing, valid ENG_LAT cycles after issue

Behaviour:
- Reset: async, asserted while rst_n=0. All outputs reset to 0, including s_ready. State returns to LOAD and all counters clear. Frame buffer contents are not reset. s_ready goes to 1 at the first clk edge after rst_n rises. Reset mid-frame abandons the frame; any in-flight engine results are discarded.
- States: LOAD → COL → DRN_C → ROW → DRN_R → UNLOAD → LOAD.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready writes buf[k], k = 0..63.
  - After the 64th accept, go to COL.
- COL (8 cycles):
  - eng_vld=1, eng_mode=0, eng_idx=c for c = 0..7, one per cycle.
  - Lane m = buf[c+8m].
- DRN_C: ENG_LAT cycles with eng_vld=0. Skipped when ENG_LAT=0.
- ROW (8 cycles):
  - eng_vld=1, eng_mode=1, eng_idx=r for r = 0..7.
  - Lane k = buf[8r+k].
- DRN_R: ENG_LAT cycles, then UNLOAD.
- Writeback:
  - An internal ENG_LAT-deep tag pipeline (valid, mode, idx) marks returning results.
  - Result lanes are written to the same buffer addresses they were read from: column c lane m → buf[c+8m]; row r lane k → buf[8r+k].
  - With ENG_LAT=0, eng_dout is captured on the issue edge.
  - The drain states guarantee every column result is written before the first row read.
- UNLOAD:
  - m_valid=1 and m_data=buf[j] for j = 0..63; j advances on m_valid&&m_ready.
  - m_data and m_last are held stable while m_valid&&!m_ready.
  - m_last=1 when j=63.
  - After the final handshake, go to LOAD; s_ready=1 on the next cycle.
- Timing: if the 64th accept occurs at edge T, COL occupies T+1..T+8 and the first m_valid is at T+17+2*ENG_LAT (T+19 for the default).
- s_ready=0 and s_data is ignored in every state except LOAD. m_valid=0 outside UNLOAD.
- eng_din is 0 whenever eng_vld=0.
- The scheduler performs no arithmetic; widths pass through unchanged. The 1/N scaling belongs to the engine.

Test Plan:
- Reset: hold rst_n=0 with s_valid=1 → all outputs 0; s_ready=1 one edge after release; drop rst_n mid-ROW → eng_vld=0 and m_valid=0 immediately; the next frame is processed correctly.
- Identity engine, ENG_LAT=1, s_data=k for k = 0..63, m_ready=1 → m_data=0..63 in order; m_last on 63; first m_valid 19 cycles after the last accept; busy covers the whole frame.
- Lane mapping check → COL idx 2 eng_din lanes = samples 2,10,...,58 with eng_mode=0; ROW idx 5 lanes = samples 40..47 with eng_mode=1; exactly 16 eng_vld pulses per frame.
- Engine model out lane m = in lane (7-m) → output index 8r+k equals input index 8(7-r)+(7-k), i.e. 63-i, confirming column writeback precedes row reads.
- Backpressure: m_ready pattern 1,0,0,1 repeating and s_valid random → m_data stable while stalled; all 64 outputs delivered in order; s_ready stays 0 until after the m_last handshake.
- ENG_LAT=0 and ENG_LAT=3 builds with the reversing engine → same results as the previous scenario; first m_valid at T+17 and T+23 respectively.
